// File: rtl/run_check_sequencer_if.sv
// Debug read port between the run/check sequencer and the dmem / expected-value ROM.
// The sequencer drives the read strobe and addresses; both memories answer one cycle later.
interface run_check_sequencer_if #(
  parameter int IDX_W = 5
) ();
  logic             chk_en;
  logic [31:0]      chk_addr;
  logic [IDX_W-1:0] exp_idx;
  logic [31:0]      chk_rdata;
  logic [31:0]      exp_data;

  modport master (
    output chk_en,
    output chk_addr,
    output exp_idx,
    input  chk_rdata,
    input  exp_data
  );

  modport slave (
    input  chk_en,
    input  chk_addr,
    input  exp_idx,
    output chk_rdata,
    output exp_data
  );
endinterface

// File: rtl/run_check_sequencer.sv
// Run-and-check sequencer for CPU bring-up: reset the CPU, run it for a bounded time,
// then freeze it and compare a window of dmem against an expected-value ROM.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_HOLD  | cpu_reset asserted for RESET_CYCLES cycles
// S_RUN   | CPU running; count cycles, watch for idle fetch
// S_CHECK | CPU frozen; issue NUM_WORDS reads, compare one cycle behind
// S_DONE  | results valid and frozen until reset
module run_check_sequencer #(
  parameter int RESET_CYCLES = 10,
  parameter int MAX_CYCLES   = 1000,
  parameter int EARLY_STOP   = 1,
  parameter int IDLE_CYCLES  = 16,
  parameter int NUM_WORDS    = 32,
  parameter int BASE_ADDR    = 0,
  parameter int CNT_W        = 16,
  parameter int IDX_W        = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               idata,
  output logic                      cpu_reset,
  output logic                      cpu_hold,
  run_check_sequencer_if.master     dbg,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_W-1:0]          fail_count,
  output logic [IDX_W-1:0]          first_fail,
  output logic [CNT_W-1:0]          cycles_used
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_HIT  = IDLE_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0]  CYC_MAX   = CNT_W'(MAX_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_WORDS - 1);
  localparam logic [31:0]       ADDR_BASE = 32'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_nxt;
  logic              run_stop;

  logic              chk_en;
  logic [31:0]       chk_addr;
  logic [IDX_W-1:0]  exp_idx;
  logic              cmp_vld;
  logic [IDX_W-1:0]  cmp_idx;
  logic              mismatch;
  logic [CNT_W-1:0]  fail_nxt;

  assign dbg.chk_en   = chk_en;
  assign dbg.chk_addr = chk_addr;
  assign dbg.exp_idx  = exp_idx;

  // Idle counter saturates so a long idle stretch with early stop disabled cannot wrap.
  always_comb begin
    idle_nxt = '0;
    if (idata == 32'd0) begin
      idle_nxt = (idle_cnt == IDLE_HIT) ? idle_cnt : idle_cnt + 1'b1;
    end
    run_stop = (cycles_used == CYC_MAX) || ((EARLY_STOP != 0) && (idle_nxt == IDLE_HIT));
    mismatch = cmp_vld && (dbg.chk_rdata != dbg.exp_data);
    fail_nxt = fail_count;
    if (mismatch && (fail_count != '1)) begin
      fail_nxt = fail_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_HOLD;
      cpu_reset   <= 1'b1;
      cpu_hold    <= 1'b0;
      chk_en      <= 1'b0;
      chk_addr    <= ADDR_BASE;
      exp_idx     <= '0;
      cmp_vld     <= 1'b0;
      cmp_idx     <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_count  <= '0;
      first_fail  <= '0;
      cycles_used <= '0;
      hold_cnt    <= '0;
      idle_cnt    <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state       <= S_RUN;
            cpu_reset   <= 1'b0;
            cycles_used <= CNT_W'(1);
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        S_RUN: begin
          idle_cnt <= idle_nxt;
          if (run_stop) begin
            state    <= S_CHECK;
            cpu_hold <= 1'b1;
            chk_en   <= 1'b1;
          end else begin
            cycles_used <= cycles_used + 1'b1;
          end
        end

        S_CHECK: begin
          cmp_vld <= chk_en;
          cmp_idx <= exp_idx;
          if (chk_en) begin
            if (exp_idx == IDX_LAST) begin
              chk_en <= 1'b0;
            end else begin
              exp_idx  <= exp_idx + 1'b1;
              chk_addr <= chk_addr + 32'd4;
            end
          end
          // Compare trails issue by one cycle; the last compare closes the check.
          if (cmp_vld) begin
            fail_count <= fail_nxt;
            if (mismatch && (fail_count == '0)) begin
              first_fail <= cmp_idx;
            end
            if (cmp_idx == IDX_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= (fail_nxt == '0);
            end
          end
        end

        S_DONE: begin
          done <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_check_sequencer.sv
// Scoreboard bench for run_check_sequencer: three instances (defaults, no early stop,
// short budget) are exercised one at a time while the others are held in reset.
module tb_run_check_sequencer;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  idx;
  } rd_t;

  typedef struct {
    int          k;
    logic [15:0] cu;
    logic [15:0] fc;
    logic [4:0]  ff;
    logic        ps;
    int          hold_n;
    int          run_n;
    int          chk_n;
  } res_t;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [31:0] idata;
  logic [2:0]  cpu_reset_s, cpu_hold_s, done_s, pass_s, chk_en_s;
  logic [15:0] fc_s [3];
  logic [15:0] cu_s [3];
  logic [4:0]  ff_s [3];
  logic [4:0]  exp_idx_s [3];
  logic [31:0] chk_addr_s [3];

  logic [31:0] dmem [32];
  logic [31:0] rom  [32];

  int cyc = 0;
  int zf = 1000000, zl = 1, zh = 0;
  int errors = 0, checks = 0;

  rd_t  rd_q [$];
  res_t res_q [$];
  rd_t  rd_cur;
  res_t res_cur;
  int   hold_n [3];
  int   run_n [3];
  int   chk_n [3];
  logic done_prev [3];

  always #5 clk = ~clk;

  // Run cycle r (1-based) is tb cycle cyc = r + 9 after the last all-reset edge.
  always @(posedge clk) cyc <= (rst == 3'b111) ? 0 : cyc + 1;
  assign idata = (((cyc - 9) >= zf) || (((cyc - 9) >= zl) && ((cyc - 9) <= zh)))
                 ? 32'h0 : 32'h0000_0013;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gen_dut
      run_check_sequencer_if #(.IDX_W(5)) dbg ();

      run_check_sequencer #(
        .MAX_CYCLES((g == 2) ? 20 : 1000),
        .EARLY_STOP((g == 1) ? 0 : 1)
      ) dut (
        .clk         (clk),
        .reset       (rst[g]),
        .idata       (idata),
        .cpu_reset   (cpu_reset_s[g]),
        .cpu_hold    (cpu_hold_s[g]),
        .dbg         (dbg),
        .done        (done_s[g]),
        .pass        (pass_s[g]),
        .fail_count  (fc_s[g]),
        .first_fail  (ff_s[g]),
        .cycles_used (cu_s[g])
      );

      assign chk_en_s[g]   = dbg.chk_en;
      assign chk_addr_s[g] = dbg.chk_addr;
      assign exp_idx_s[g]  = dbg.exp_idx;

      // Synchronous-read memories: data appears the cycle after the strobe.
      always @(posedge clk) begin
        if (dbg.chk_en) begin
          dbg.chk_rdata <= dmem[dbg.chk_addr[6:2]];
          dbg.exp_data  <= rom[dbg.exp_idx];
        end
      end
    end
  endgenerate

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: counts phase lengths per instance, pops read and result expectations.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        hold_n[k]    = 0;
        run_n[k]     = 0;
        chk_n[k]     = 0;
        done_prev[k] = 1'b0;
      end else begin
        if (cpu_reset_s[k])      hold_n[k]++;
        else if (!cpu_hold_s[k]) run_n[k]++;
        else if (!done_s[k])     chk_n[k]++;

        if (chk_en_s[k]) begin
          chk("read expected", 32'(rd_q.size() > 0), 1);
          chk("cpu_hold during read", 32'(cpu_hold_s[k]), 1);
          if (rd_q.size() > 0) begin
            rd_cur = rd_q.pop_front();
            chk("chk_addr", chk_addr_s[k], rd_cur.addr);
            chk("exp_idx", 32'(exp_idx_s[k]), 32'(rd_cur.idx));
          end
        end

        if (done_s[k] && !done_prev[k]) begin
          chk("result expected", 32'(res_q.size() > 0), 1);
          if (res_q.size() > 0) begin
            res_cur = res_q.pop_front();
            chk("instance", 32'(k), 32'(res_cur.k));
            chk("cycles_used", 32'(cu_s[k]), 32'(res_cur.cu));
            chk("fail_count", 32'(fc_s[k]), 32'(res_cur.fc));
            chk("first_fail", 32'(ff_s[k]), 32'(res_cur.ff));
            chk("pass", 32'(pass_s[k]), 32'(res_cur.ps));
            chk("cpu_reset cycles", 32'(hold_n[k]), 32'(res_cur.hold_n));
            chk("run cycles", 32'(run_n[k]), 32'(res_cur.run_n));
            chk("check cycles", 32'(chk_n[k]), 32'(res_cur.chk_n));
          end
        end
        if (done_prev[k] && !done_s[k]) chk("done sticky", 0, 1);
        done_prev[k] = done_s[k];
      end
    end
  end

  // abort_at < 0: full run checked at done; otherwise reset when word abort_at is issued.
  task automatic do_run(int k, int zf_i, int zl_i, int zh_i, logic [31:0] bad, res_t e, int abort_at);
    int c;
    @(posedge clk); #1;
    rst = 3'b111;
    zf = zf_i; zl = zl_i; zh = zh_i;
    for (int i = 0; i < 32; i++) dmem[i] = bad[i] ? (rom[i] ^ 32'h0000_0100) : rom[i];
    for (int i = 0; i < ((abort_at >= 0) ? abort_at : 32); i++)
      rd_q.push_back('{addr: 32'(4 * i), idx: 5'(i)});
    if (abort_at < 0) res_q.push_back(e);
    repeat (2) @(posedge clk);
    #1 rst[k] = 1'b0;
    c = 0;
    if (abort_at < 0) begin
      while (!done_s[k] && c < 1500) begin
        @(posedge clk); #1;
        c++;
      end
      chk("done reached", 32'(done_s[k]), 1);
      repeat (4) @(posedge clk);
      #1;
      chk("done held", 32'(done_s[k]), 1);
      chk("reads drained", 32'(rd_q.size()), 0);
      chk("results drained", 32'(res_q.size()), 0);
    end else begin
      while (!(chk_en_s[k] && exp_idx_s[k] == 5'(abort_at)) && c < 300) begin
        @(posedge clk); #1;
        c++;
      end
      chk("abort point reached", 32'(chk_en_s[k]), 1);
      chk("fail_count before abort", 32'(fc_s[k]), 32'(e.fc));
      rst = 3'b111;
      @(posedge clk); #1;
      chk("abort cpu_reset", 32'(cpu_reset_s[k]), 1);
      chk("abort cpu_hold", 32'(cpu_hold_s[k]), 0);
      chk("abort done", 32'(done_s[k]), 0);
      chk("abort fail_count", 32'(fc_s[k]), 0);
      chk("abort chk_en", 32'(chk_en_s[k]), 0);
      chk("abort reads drained", 32'(rd_q.size()), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hC0DE_0000 + 32'(i * 977);
    for (int i = 0; i < 32; i++) dmem[i] = rom[i];

    repeat (2) @(posedge clk);
    #1;
    chk("reset cpu_reset", 32'(cpu_reset_s[0]), 1);
    chk("reset cpu_hold", 32'(cpu_hold_s[0]), 0);
    chk("reset chk_en", 32'(chk_en_s[0]), 0);
    chk("reset chk_addr", chk_addr_s[0], 0);
    chk("reset done", 32'(done_s[0]), 0);
    chk("reset cycles_used", 32'(cu_s[0]), 0);

    // Idle from run cycle 40: 16 zero fetches end at cycle 55.
    do_run(0, 40, 1, 0, 32'h0,
           '{k: 0, cu: 16'd55, fc: 16'd0, ff: 5'd0, ps: 1'b1, hold_n: 10, run_n: 55, chk_n: 33}, -1);
    // Idle from cycle 1, words 3 and 17 corrupted.
    do_run(0, 1, 1, 0, 32'h0002_0008,
           '{k: 0, cu: 16'd16, fc: 16'd2, ff: 5'd3, ps: 1'b0, hold_n: 10, run_n: 16, chk_n: 33}, -1);
    // Abort while word 10 is issued; word 3 already counted as a mismatch.
    do_run(0, 1, 1, 0, 32'h0000_0008,
           '{k: 0, cu: 16'd0, fc: 16'd1, ff: 5'd0, ps: 1'b0, hold_n: 0, run_n: 0, chk_n: 0}, 10);
    // Rerun: 15-cycle idle burst (5..19) must not stop; idle from 30 stops at 45.
    do_run(0, 30, 5, 19, 32'h0,
           '{k: 0, cu: 16'd45, fc: 16'd0, ff: 5'd0, ps: 1'b1, hold_n: 10, run_n: 45, chk_n: 33}, -1);
    // No early stop, idata always 0: full 1000-cycle budget, last word corrupted.
    do_run(1, -100, 1, 0, 32'h8000_0000,
           '{k: 1, cu: 16'd1000, fc: 16'd1, ff: 5'd31, ps: 1'b0, hold_n: 10, run_n: 1000, chk_n: 33}, -1);
    // Busy CPU with a 20-cycle budget.
    do_run(2, 1000000, 1, 0, 32'h0,
           '{k: 2, cu: 16'd20, fc: 16'd0, ff: 5'd0, ps: 1'b1, hold_n: 10, run_n: 20, chk_n: 33}, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
